// File: rtl/or1200_print_uart_tx.sv
// ---------------------------------------------------------------------------
// or1200_print_uart_tx
//
// Print-path UART transmitter. Bytes pushed by the processor-side print
// interface are queued in a small circular FIFO and sent as 8N1 serial on a
// dedicated TXD pin. A new frame follows the previous stop bit with no idle
// gap while bytes are queued.
//
// Parameters:
//   CLK_HZ     - clock frequency in Hz
//   BAUD       - serial bit rate; bit period DIV = round(CLK_HZ / BAUD)
//   FIFO_DEPTH - FIFO entries, power of two, >= 2
//
// Ports:
//   clk_i        - system clock, rising edge
//   rst_i        - asynchronous, active-high reset
//   tf_push_i    - one-cycle push strobe
//   print_data_i - byte written when tf_push_i is high
//   uart_txd_o   - serial output, idle high
//   fifo_full_o  - FIFO holds FIFO_DEPTH bytes
//   fifo_empty_o - FIFO holds no bytes
//   overflow_o   - sticky: a push was dropped because the FIFO was full
//   busy_o       - serializer is sending a frame
//
// Configuration:
//   PRINT_TX_CRLF_EN - when defined, every 0x0A taken from the FIFO goes out
//                      as 0x0D followed by 0x0A (one FIFO pop per byte).
// ---------------------------------------------------------------------------
module or1200_print_uart_tx #(
    parameter int unsigned CLK_HZ     = 48000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tf_push_i,
    input  logic [7:0] print_data_i,
    output logic       uart_txd_o,
    output logic       fifo_full_o,
    output logic       fifo_empty_o,
    output logic       overflow_o,
    output logic       busy_o
);

    localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // FIFO storage and pointers (extra MSB is the wrap bit)
    // ------------------------------------------------------------------
    logic [7:0]   mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         fifo_full_q, fifo_empty_q, overflow_q;
    logic [7:0]   head;

    // Serializer state
    state_e           state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             txd_q;

    // Handshake between FSM and FIFO
    logic       bit_end;     // last clock of the current bit period
    logic       load_req;    // FSM is at a point where it may take a byte
    logic       byte_avail;  // something is waiting to be sent
    logic       load_fire;   // FSM takes a byte this cycle
    logic       pop;         // FIFO head consumed this cycle
    logic       push_ok;
    logic [7:0] load_byte;

    assign head      = mem[rd_ptr_q[AW-1:0]];
    assign bit_end   = (baud_cnt_q == CNT_LAST);
    assign load_fire = load_req && byte_avail;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_req = 1'b0;
        case (state_q)
            S_IDLE:  load_req = 1'b1;
            S_STOP:  load_req = bit_end;
            default: load_req = 1'b0;
        endcase
    end

`ifdef PRINT_TX_CRLF_EN
    // Set while the LF half of a CR/LF pair still has to be sent; the LF is
    // regenerated here rather than re-read, so the FIFO pops only once.
    logic lf_pend_q;

    assign byte_avail = !fifo_empty_q || lf_pend_q;
    assign pop        = load_fire && !lf_pend_q;
    assign load_byte  = lf_pend_q ? 8'h0A : ((head == 8'h0A) ? 8'h0D : head);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lf_pend_q <= 1'b0;
        end else if (load_fire) begin
            lf_pend_q <= !lf_pend_q && (head == 8'h0A);
        end
    end
`else
    assign byte_avail = !fifo_empty_q;
    assign pop        = load_fire;
    assign load_byte  = head;
`endif

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign push_ok = tf_push_i && (!fifo_full_q || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_full_q  <= 1'b0;
            fifo_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_empty_q <= (wr_ptr_d == rd_ptr_d);
            fifo_full_q  <= (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                            (wr_ptr_d[AW] != rd_ptr_d[AW]);
            if (tf_push_i && !push_ok) overflow_q <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; reset clears the pointers, which
    // makes every entry unreachable, and leaving the array unreset lets it map
    // onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= print_data_i;
    end

    // ------------------------------------------------------------------
    // Serializer FSM; txd_q is registered and always holds the level of the
    // bit currently on the line.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_fire) begin
                        shift_q    <= load_byte;
                        baud_cnt_q <= '0;
                        txd_q      <= 1'b0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        txd_q      <= shift_q[0];
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (load_fire) begin
                            // Next byte starts right after this stop bit.
                            shift_q <= load_byte;
                            txd_q   <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign uart_txd_o   = txd_q;
    assign fifo_full_o  = fifo_full_q;
    assign fifo_empty_o = fifo_empty_q;
    assign overflow_o   = overflow_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_or1200_print_uart_tx.sv
// ---------------------------------------------------------------------------
// Testbench for or1200_print_uart_tx with CLK_HZ=1 MHz, BAUD=100 kHz
// (10 clocks per bit), FIFO_DEPTH=4. A line decoder recovers frames from
// uart_txd_o by sampling bit centres; received bytes are compared with the
// byte list the reference model says should appear on the line.
// ---------------------------------------------------------------------------
module tb_or1200_print_uart_tx;

    localparam int DIV   = 10;
    localparam int FRAME = 10 * DIV;

    logic       clk;
    logic       rst;
    logic       tf_push;
    logic [7:0] print_data;
    logic       txd, full, empty, ovf, busy;

    or1200_print_uart_tx #(
        .CLK_HZ     (1000000),
        .BAUD       (100000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tf_push_i    (tf_push),
        .print_data_i (print_data),
        .uart_txd_o   (txd),
        .fifo_full_o  (full),
        .fifo_empty_o (empty),
        .overflow_o   (ovf),
        .busy_o       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter: at the falling edge after edge N, cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the ordered list of bytes that must appear on the line
    // ------------------------------------------------------------------
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] stim_q[$];

    task automatic expect_byte(input logic [7:0] b);
`ifdef PRINT_TX_CRLF_EN
        if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(b);
    endtask

    task automatic compare_rx(input string tag);
        int n;
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Line decoder: sample the centre of each of the 10 bit cells
    // ------------------------------------------------------------------
    always begin : line_decoder
        logic [9:0] fr;
        int         start_t;
        bit         abort;
        @(negedge clk);
        if (!rst && txd === 1'b0) begin
            start_t = cyc;
            abort   = 1'b0;
            for (int j = 0; j < 10; j++) begin
                for (int c = 0; c < ((j == 0) ? DIV / 2 : DIV); c++) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                end
                fr[j] = txd;
            end
            if (!abort) begin
                check("rx_start_bit", {31'd0, fr[0]}, 32'd0);
                check("rx_stop_bit",  {31'd0, fr[9]}, 32'd1);
                rx_q.push_back(fr[8:1]);
                rx_t.push_back(start_t);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Pushes stim_q; returns at the falling edge after the last push edge.
    task automatic push_seq(input int max_gap, output int first_edge);
        first_edge = 0;
        @(negedge clk);
        for (int i = 0; i < stim_q.size(); i++) begin
            tf_push    = 1'b1;
            print_data = stim_q[i];
            @(negedge clk);
            if (i == 0) first_edge = cyc;
            tf_push = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
        stim_q.delete();
    endtask

    // Waits until the serializer goes idle; returns the edge where busy fell.
    task automatic wait_idle(output int fall_edge);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        fall_edge = cyc;
    endtask

    task automatic wait_until(input int edge_no);
        while (cyc < edge_no) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        int         n0, fall, errs, frames, nb;
        logic [7:0] sb, b;
        logic       exp_txd, exp_busy;

        rst        = 1'b1;
        tf_push    = 1'b0;
        print_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_txd",   {31'd0, txd},   32'd1);
        check("reset_empty", {31'd0, empty}, 32'd1);
        check("reset_full",  {31'd0, full},  32'd0);
        check("reset_ovf",   {31'd0, ovf},   32'd0);
        check("reset_busy",  {31'd0, busy},  32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // ---- single byte: exact waveform ------------------------------
        sb = 8'h55;
        stim_q.push_back(sb);
        expect_byte(sb);
        push_seq(0, n0);
        check("single_empty_after_push", {31'd0, empty}, 32'd0);
        for (int m = n0; m <= n0 + FRAME + 1; m++) begin
            if (m <= n0)                   exp_txd = 1'b1;
            else if (m <= n0 + DIV)        exp_txd = 1'b0;
            else if (m <= n0 + 9 * DIV)    exp_txd = sb[(m - n0 - DIV - 1) / DIV];
            else                           exp_txd = 1'b1;
            exp_busy = (m >= n0 + 1) && (m <= n0 + FRAME);
            check("single_txd",  {31'd0, txd},  {31'd0, exp_txd});
            check("single_busy", {31'd0, busy}, {31'd0, exp_busy});
            @(negedge clk);
        end
        compare_rx("single");

        // ---- back-to-back ---------------------------------------------
        stim_q = '{8'h41, 8'h42};
        expect_byte(8'h41);
        expect_byte(8'h42);
        push_seq(0, n0);
        wait_idle(fall);
        check("b2b_duration", fall - n0, 2 * FRAME + 1);
        if (rx_t.size() == 2) check("b2b_gap", rx_t[1] - rx_t[0], FRAME);
        else                  check("b2b_frames", rx_t.size(), 2);
        compare_rx("b2b");

        // ---- overflow -------------------------------------------------
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        for (int i = 1; i <= 5; i++) expect_byte(8'(i));
        push_seq(0, n0);
        check("ovf_full", {31'd0, full}, 32'd1);
        check("ovf_flag", {31'd0, ovf},  32'd1);
        wait_idle(fall);
        check("ovf_sticky",     {31'd0, ovf},   32'd1);
        check("ovf_empty_end",  {31'd0, empty}, 32'd1);
        check("ovf_duration",   fall - n0, 5 * FRAME + 1);
        compare_rx("ovf");

        // ---- reset mid-frame (during data bit 3) ----------------------
        stim_q = '{8'hA5, 8'h5A, 8'h3C};
        push_seq(0, n0);
        wait_until(n0 + DIV + 3 * DIV + 5);
        #2 rst = 1'b1;
        #1;
        check("rst_txd",   {31'd0, txd},   32'd1);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full",  {31'd0, full},  32'd0);
        check("rst_ovf",   {31'd0, ovf},   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        errs = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) errs++;
        end
        check("rst_line_quiet", errs, 0);
        compare_rx("rst");

        // ---- full FIFO with simultaneous pop --------------------------
        stim_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        for (int i = 0; i < 5; i++) expect_byte(8'h11 + 8'(i));
        expect_byte(8'h77);
        push_seq(0, n0);
        check("fullpop_full_before", {31'd0, full}, 32'd1);
        // Second frame's pop happens at edge n0 + FRAME + 1.
        wait_until(n0 + FRAME);
        tf_push    = 1'b1;
        print_data = 8'h77;
        @(negedge clk);
        tf_push = 1'b0;
        check("fullpop_full_after", {31'd0, full}, 32'd1);
        check("fullpop_ovf",        {31'd0, ovf},  32'd0);
        wait_idle(fall);
        check("fullpop_ovf_end",  {31'd0, ovf}, 32'd0);
        check("fullpop_duration", fall - n0, 6 * FRAME + 1);
        compare_rx("fullpop");

        // ---- line feed ------------------------------------------------
        stim_q.push_back(8'h0A);
        expect_byte(8'h0A);
        frames = exp_q.size();
        push_seq(0, n0);
        errs = 0;
        @(negedge clk);
        while (busy && cyc < n0 + 3 * FRAME) begin
            if (empty !== 1'b1) errs++;
            @(negedge clk);
        end
        check("lf_empty_throughout", errs, 0);
        check("lf_duration", cyc - n0, frames * FRAME + 1);
        compare_rx("lf");

        // ---- randomized bursts ----------------------------------------
        for (int it = 0; it < 8; it++) begin
            nb = $urandom_range(5, 1);
            for (int i = 0; i < nb; i++) begin
                b = ($urandom_range(3, 0) == 0) ? 8'h0A : 8'($urandom);
                stim_q.push_back(b);
                expect_byte(b);
            end
            frames = exp_q.size();
            push_seq(3, n0);
            wait_idle(fall);
            check("rand_duration", fall - n0, frames * FRAME + 1);
            check("rand_ovf",      {31'd0, ovf},   32'd0);
            check("rand_empty",    {31'd0, empty}, 32'd1);
            compare_rx("rand");
            repeat ($urandom_range(20, 1)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
